// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: widths, operation codes,
// FSM encoding and the conditional two's-complement helpers.
package mips_pkg;

  localparam int LARGURA = 32;
  localparam int N_ITER  = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    AJUSTA  = 2'b10
  } estado_e;

  function automatic logic [LARGURA-1:0] nega_cond32(input logic [LARGURA-1:0] v,
                                                     input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*LARGURA-1:0] nega_cond64(input logic [2*LARGURA-1:0] v,
                                                       input logic en);
    return en ? -v : v;
  endfunction

endpackage

// File: rtl/unidade_mult_div_if.sv
// Bus between pipeline control / register file and the multiply/divide unit.
interface unidade_mult_div_if;
  import mips_pkg::*;

  logic               inicia;
  logic [1:0]         operacao;
  logic [LARGURA-1:0] operando_a;
  logic [LARGURA-1:0] operando_b;
  logic               escreve_hi;
  logic               escreve_lo;
  logic [LARGURA-1:0] dados_hi_lo;
  logic               ocupado;
  logic               pronto;
  logic               div_por_zero;
  logic [LARGURA-1:0] hi;
  logic [LARGURA-1:0] lo;

  modport master (
    output inicia, operacao, operando_a, operando_b,
           escreve_hi, escreve_lo, dados_hi_lo,
    input  ocupado, pronto, div_por_zero, hi, lo
  );

  modport slave (
    input  inicia, operacao, operando_a, operando_b,
           escreve_hi, escreve_lo, dados_hi_lo,
    output ocupado, pronto, div_por_zero, hi, lo
  );

endinterface

// File: rtl/unidade_mult_div.sv
// Iterative MIPS multiply/divide unit holding HI/LO: shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, signs fixed up at the end.
module unidade_mult_div
  import mips_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  unidade_mult_div_if.slave  bus
);

  estado_e              estado_q, estado_d;
  logic [4:0]           cont_q, cont_d;
  logic                 eh_div_q, eh_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 zero_q, zero_d;
  logic [LARGURA-1:0]   a_orig_q, a_orig_d;
  logic [LARGURA-1:0]   b_q, b_d;
  logic [2*LARGURA-1:0] acc_q, acc_d;
  logic [LARGURA-1:0]   rem_q, rem_d;
  logic [LARGURA-1:0]   hi_q, hi_d;
  logic [LARGURA-1:0]   lo_q, lo_d;
  logic                 pronto_q, pronto_d;
  logic                 dz_q, dz_d;

  op_e                  op_in;
  logic                 com_sinal;
  logic [LARGURA-1:0]   mag_a, mag_b;
  logic [LARGURA:0]     soma_mul;
  logic [LARGURA:0]     rem_desl, rem_dif;
  logic                 cabe;
  logic [2*LARGURA-1:0] prod_final;
  logic [LARGURA-1:0]   quo_final, rem_final;

  assign op_in     = op_e'(bus.operacao);
  assign com_sinal = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign mag_a     = nega_cond32(bus.operando_a, com_sinal & bus.operando_a[LARGURA-1]);
  assign mag_b     = nega_cond32(bus.operando_b, com_sinal & bus.operando_b[LARGURA-1]);

  // Multiply: upper half accumulates, multiplier bits leave through the bottom.
  assign soma_mul = {1'b0, acc_q[2*LARGURA-1:LARGURA]} +
                    (acc_q[0] ? {1'b0, b_q} : '0);

  // Divide: the remainder stays below the divisor, so bit 32 of the
  // difference is set exactly when the trial subtraction underflows.
  assign rem_desl = {rem_q, acc_q[LARGURA-1]};
  assign rem_dif  = rem_desl - {1'b0, b_q};
  assign cabe     = ~rem_dif[LARGURA];

  assign prod_final = nega_cond64(acc_q, neg_res_q);
  assign quo_final  = nega_cond32(acc_q[LARGURA-1:0], neg_res_q);
  assign rem_final  = nega_cond32(rem_q, neg_rem_q);

  always_comb begin
    estado_d  = estado_q;
    cont_d    = cont_q;
    eh_div_d  = eh_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    a_orig_d  = a_orig_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pronto_d  = 1'b0;
    dz_d      = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (bus.inicia) begin
          eh_div_d  = (op_in == OP_DIV) || (op_in == OP_DIVU);
          neg_res_d = com_sinal & (bus.operando_a[LARGURA-1] ^ bus.operando_b[LARGURA-1]);
          neg_rem_d = com_sinal & bus.operando_a[LARGURA-1];
          zero_d    = (bus.operando_b == '0);
          a_orig_d  = bus.operando_a;
          b_d       = mag_b;
          acc_d     = {{LARGURA{1'b0}}, mag_a};
          rem_d     = '0;
          cont_d    = '0;
          estado_d  = CALCULA;
        end else begin
          if (bus.escreve_hi) hi_d = bus.dados_hi_lo;
          if (bus.escreve_lo) lo_d = bus.dados_hi_lo;
        end
      end

      CALCULA: begin
        if (eh_div_q) begin
          acc_d = {acc_q[2*LARGURA-1:LARGURA], acc_q[LARGURA-2:0], cabe};
          rem_d = cabe ? rem_dif[LARGURA-1:0] : rem_desl[LARGURA-1:0];
        end else begin
          acc_d = {soma_mul, acc_q[LARGURA-1:1]};
        end
        cont_d = cont_q + 5'd1;
        if (cont_q == 5'(N_ITER - 1)) estado_d = AJUSTA;
      end

      AJUSTA: begin
        if (eh_div_q && zero_q) begin
          hi_d = a_orig_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else if (eh_div_q) begin
          hi_d = rem_final;
          lo_d = quo_final;
        end else begin
          {hi_d, lo_d} = prod_final;
        end
        pronto_d = 1'b1;
        estado_d = OCIOSO;
      end

      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q  <= OCIOSO;
      cont_q    <= '0;
      eh_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      a_orig_q  <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pronto_q  <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      eh_div_q  <= eh_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      a_orig_q  <= a_orig_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pronto_q  <= pronto_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.ocupado      = (estado_q != OCIOSO);
  assign bus.pronto       = pronto_q;
  assign bus.div_por_zero = dz_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Self-checking bench for unidade_mult_div: directed cases with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_unidade_mult_div;
  import mips_pkg::*;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] l;
    logic        dz;
  } res_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  unidade_mult_div_if bus();

  unidade_mult_div dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Reference arithmetic straight from the MIPS definitions.
  function automatic res_t reference(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    res_t        r;
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      2'b00: begin sp = longint'(sa) * longint'(sb); {r.h, r.l} = sp; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; {r.h, r.l} = up; end
      2'b10: begin
        if (b == 32'h0) begin r.h = a; r.l = 32'hFFFFFFFF; r.dz = 1'b1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          r.l = 32'h80000000; r.h = 32'h0;
        end else begin r.l = 32'(sa / sb); r.h = 32'(sa % sb); end
      end
      default: begin
        if (b == 32'h0) begin r.h = a; r.l = 32'hFFFFFFFF; r.dz = 1'b1; end
        else begin r.l = a / b; r.h = a % b; end
      end
    endcase
    return r;
  endfunction

  // Cycle model: an accepted start keeps the unit busy for 33 cycles and the
  // result lands on the 33rd edge after acceptance.
  int          m_cnt    = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;
  logic        m_pronto = 1'b0;
  logic        m_dz     = 1'b0;
  res_t        m_pend   = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt    <= 0;
      m_hi     <= '0;
      m_lo     <= '0;
      m_pronto <= 1'b0;
      m_dz     <= 1'b0;
    end else begin
      m_pronto <= 1'b0;
      m_dz     <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi     <= m_pend.h;
          m_lo     <= m_pend.l;
          m_pronto <= 1'b1;
          m_dz     <= m_pend.dz;
        end
      end else if (bus.inicia) begin
        m_pend <= reference(bus.operacao, bus.operando_a, bus.operando_b);
        m_cnt  <= 33;
      end else begin
        if (bus.escreve_hi) m_hi <= bus.dados_hi_lo;
        if (bus.escreve_lo) m_lo <= bus.dados_hi_lo;
      end
    end
  end

  task automatic check_value(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Every cycle the outputs must match the model.
  always @(negedge clock) begin
    check_value("model.ocupado", 32'(bus.ocupado), 32'(m_cnt > 0));
    check_value("model.pronto", 32'(bus.pronto), 32'(m_pronto));
    check_value("model.div_por_zero", 32'(bus.div_por_zero), 32'(m_dz));
    check_value("model.hi", bus.hi, m_hi);
    check_value("model.lo", bus.lo, m_lo);
  end

  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    @(posedge clock); #1;
    bus.inicia     = 1'b1;
    bus.operacao   = op;
    bus.operando_a = a;
    bus.operando_b = b;
    @(posedge clock); #1;
    bus.inicia = 1'b0;
  endtask

  // Counts falling edges until pronto; busy is required on every earlier one.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (!bus.pronto) check_value("ocupado_while_running", 32'(bus.ocupado), 32'd1);
    end while (!bus.pronto && n < 60);
    if (!bus.pronto) begin
      miscompares++;
      $display("[TB] FAIL pronto_timeout: got no pronto after %0d cycles, expected 34", n);
    end
  endtask

  task automatic check_output(input string name, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                              input logic exp_dz);
    int n;
    apply_stimulus(op, a, b);
    wait_done(n);
    check_value({name, ".latency"}, 32'(n), 32'd34);
    check_value({name, ".hi"}, bus.hi, exp_hi);
    check_value({name, ".lo"}, bus.lo, exp_lo);
    check_value({name, ".ocupado"}, 32'(bus.ocupado), 32'd0);
    check_value({name, ".div_por_zero"}, 32'(bus.div_por_zero), 32'(exp_dz));
    @(negedge clock);
    check_value({name, ".pronto_pulse"}, 32'(bus.pronto), 32'd0);
    check_value({name, ".dz_pulse"}, 32'(bus.div_por_zero), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    bus.inicia      = 1'b0;
    bus.operacao    = 2'b00;
    bus.operando_a  = '0;
    bus.operando_b  = '0;
    bus.escreve_hi  = 1'b0;
    bus.escreve_lo  = 1'b0;
    bus.dados_hi_lo = '0;

    #1 reset_n = 1'b0;
    #1;
    check_value("reset.hi", bus.hi, 32'h0);
    check_value("reset.lo", bus.lo, 32'h0);
    check_value("reset.ocupado", 32'(bus.ocupado), 32'd0);
    check_value("reset.pronto", 32'(bus.pronto), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    check_output("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    check_output("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    check_output("divu_100_7", 2'b11, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0);
    check_output("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    check_output("div_overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    check_output("div_by_zero", 2'b10, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    check_output("divu_by_zero", 2'b11, 32'h00000042, 32'h0, 32'h00000042, 32'hFFFFFFFF, 1'b1);

    // MTLO while idle, then writes and a second start during a multiply.
    @(posedge clock); #1;
    bus.escreve_lo  = 1'b1;
    bus.dados_hi_lo = 32'hCAFEBABE;
    @(posedge clock); #1;
    bus.escreve_lo = 1'b0;
    @(negedge clock);
    check_value("mtlo.lo", bus.lo, 32'hCAFEBABE);
    apply_stimulus(2'b01, 32'd3, 32'd5);
    repeat (3) @(posedge clock);
    #1;
    bus.inicia      = 1'b1;
    bus.operacao    = 2'b00;
    bus.operando_a  = 32'd9;
    bus.operando_b  = 32'd9;
    bus.escreve_hi  = 1'b1;
    bus.dados_hi_lo = 32'hDEADBEEF;
    @(posedge clock); #1;
    bus.inicia     = 1'b0;
    bus.escreve_hi = 1'b0;
    wait_done(n);
    check_value("busy_ignore.hi", bus.hi, 32'h0);
    check_value("busy_ignore.lo", bus.lo, 32'd15);
    repeat (40) @(negedge clock);
    check_value("busy_ignore.no_second", bus.lo, 32'd15);

    // Asynchronous reset in the middle of a multiply.
    apply_stimulus(2'b00, 32'd2, 32'd2);
    repeat (8) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_value("abort.ocupado", 32'(bus.ocupado), 32'd0);
    check_value("abort.hi", bus.hi, 32'h0);
    check_value("abort.lo", bus.lo, 32'h0);
    check_value("abort.pronto", 32'(bus.pronto), 32'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    check_output("after_reset_6x7", 2'b01, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);

    // Random traffic, including starts/writes while busy and one mid-run reset.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clock); #1;
      bus.inicia      = ($urandom_range(0, 2) == 0);
      bus.operacao    = 2'($urandom_range(0, 3));
      bus.operando_a  = pick_operand();
      bus.operando_b  = pick_operand();
      bus.escreve_hi  = ($urandom_range(0, 9) == 0);
      bus.escreve_lo  = ($urandom_range(0, 9) == 0);
      bus.dados_hi_lo = $urandom;
      if (c == 700) begin
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
      end
    end
    @(posedge clock); #1;
    bus.inicia     = 1'b0;
    bus.escreve_hi = 1'b0;
    bus.escreve_lo = 1'b0;
    repeat (40) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unidade_mult_div.md
Name: unidade_mult_div

Overview:
Iterative multiply/divide unit sitting directly downstream of the register file. It consumes the RS/RT read values and executes MIPS MULT, MULTU, DIV and DIVU in a fixed number of cycles. It holds the architectural HI/LO registers and also supports MTHI/MTLO writes. Control stalls the pipeline on `ocupado`.

Parameters:
- LARGURA, 32, operand and HI/LO width. Only 32 is supported; the test values below assume 32.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inicia  in  1  start request; sampled only in OCIOSO.
- operacao  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- operando_a  in  LARGURA  RS value: multiplicand or dividend.
- operando_b  in  LARGURA  RT value: multiplier or divisor.
- escreve_hi  in  1  MTHI strobe.
- escreve_lo  in  1  MTLO strobe.
- dados_hi_lo  in  LARGURA  data for MTHI/MTLO.
- ocupado  out  1  operation in progress.
- pronto  out  1  one-cycle completion pulse.
- div_por_zero  out  1  one-cycle pulse with `pronto` when a divide has divisor 0.
- hi  out  LARGURA  HI register.
- lo  out  LARGURA  LO register.

Behaviour:
- Clock and reset are fixed:
  - One clock, `clock`.
  - Reset `reset_n` is asynchronous and active-low.
- Reset state, applied immediately on `reset_n`=0 regardless of clock:
  - hi=0, lo=0, ocupado=0, pronto=0, div_por_zero=0.
  - FSM in OCIOSO, iteration counter=0.
  - Reset mid-operation aborts the operation; no partial result is ever written.
- FSM states: OCIOSO, CALCULA, AJUSTA.
- OCIOSO, `inicia`=1 sampled at edge T:
  - Latch operation, operands and sign flags.
  - Convert signed operands to magnitudes.
  - Counter=0; go to CALCULA. `ocupado`=1 from cycle T+1.
- CALCULA performs one iteration per edge for exactly 32 edges (counter 0..31), then goes to AJUSTA.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 33-bit partial remainder.
- AJUSTA, one edge:
  - Apply sign correction.
  - Write hi/lo.
  - Pulse `pronto` (and `div_por_zero` when applicable).
  - Return to OCIOSO.
- Latency and `ocupado` timing:
  - `ocupado` is high during cycles T+1..T+33.
  - New hi/lo and `pronto`=1 are visible in cycle T+34, with `ocupado`=0.
  - A new `inicia` is accepted in cycle T+34.
- Arithmetic results:
  - MULT/MULTU: {hi,lo} = full 64-bit product.
  - Signed multiply negates the product when operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Divide boundary cases:
  - Divisor 0: same latency; hi=operando_a, lo=0xFFFFFFFF, `div_por_zero`=1 with `pronto`. Applies to both DIV and DIVU.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No flag.
- `inicia` while `ocupado`: ignored, with no queueing. Operand changes during CALCULA have no effect.
- MTHI/MTLO writes:
  - `escreve_hi`/`escreve_lo` with `ocupado`=0 write `dados_hi_lo` on the edge.
  - Both asserted together write both registers.
  - Ignored while `ocupado`=1.
  - Ignored if `inicia` is accepted in the same cycle; the operation result wins.
- hi/lo hold their value at all times other than AJUSTA and accepted writes.
- `pronto` is never asserted in consecutive cycles.

Decomposition:
- Shared package (`mips_pkg`) holds:
  - LARGURA.
  - Operation codes OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state encoding (OCIOSO/CALCULA/AJUSTA).
  - Iteration count constant N_ITER=32.
- No sub-module is required. Conditional two's-complement negation is a package function, not an instance.

Test Plan:
1. MULT, a=0xFFFFFFFD (-3), b=7, inicia at T -> cycle T+34: hi=0xFFFFFFFF, lo=0xFFFFFFEB, pronto=1 for one cycle; ocupado=1 over T+1..T+33.
2. MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
3. DIV -7/2 (a=0xFFFFFFF9, b=2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIV, a=0x12345678, b=0 -> at T+34: hi=0x12345678, lo=0xFFFFFFFF, div_por_zero=1 with pronto; both are 0 the next cycle.
5. MTLO 0xCAFEBABE while idle -> lo=0xCAFEBABE next cycle. Start MULTU 3*5, then pulse escreve_hi and inicia at T+5 -> both ignored; final hi=0, lo=15.
6. Start MULT 2*2, drop reset_n at T+10 (between edges) -> hi=lo=0 and ocupado=0 immediately, with no pronto. After release, MULTU 6*7 -> lo=42 exactly 34 cycles after inicia.
